// File: rtl/lane_striping_scrambler.sv
// lane_striping_scrambler: stripes one symbol stream across active lanes with per-lane PCIe Gen1/2 scrambling.
// Optional macro LANE_REVERSAL_EN adds lane_reverse_i, mapping logical lane k onto physical lane N-1-k.
module lane_striping_scrambler #(
    parameter int          NUM_LANES  = 4,
    parameter logic [15:0] LFSR_SEED  = 16'hFFFF,
    parameter logic [7:0]  PAD_SYMBOL = 8'hF7
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NUM_LANES-1:0]   lane_enable_i,
`ifdef LANE_REVERSAL_EN
    input  logic                   lane_reverse_i,
`endif
    input  logic                   bypass_scrambler_i,
    input  logic [7:0]             data_i,
    input  logic                   is_k_i,
    input  logic                   is_ordered_set_i,
    input  logic                   last_i,
    input  logic                   valid_i,
    output logic                   ready_o,
    output logic [NUM_LANES*8-1:0] lane_data_o,
    output logic [NUM_LANES-1:0]   lane_is_k_o,
    output logic                   lane_valid_o,
    input  logic                   lane_ready_i
);
    localparam int IW = NUM_LANES > 1 ? $clog2(NUM_LANES) : 1;
    localparam int NW = $clog2(NUM_LANES + 1);
    typedef enum logic {FILL, HOLD} state_t;
    state_t state;
    logic [IW-1:0] idx, sel;
    logic [NW-1:0] n_q, n_cur, n_eff;
    logic rev_q, rev_cur, rev_eff, run, act, sk, com, skp;
    logic [7:0] sd;
    logic [7:0] acc_d [NUM_LANES], grp_d [NUM_LANES], src_d [NUM_LANES];
    logic acc_k [NUM_LANES], grp_k [NUM_LANES], src_k [NUM_LANES];
    logic [15:0] lfsr [NUM_LANES], lfsr_n [NUM_LANES];
    logic [NUM_LANES*8-1:0] scr_d;
    logic [NUM_LANES-1:0] scr_k;
    logic fill, idx_z, os_pad, take, done, out_free, move;

    function automatic logic [15:0] adv8(input logic [15:0] s);
        adv8 = s;
        for (int b = 0; b < 8; b++) adv8 = {adv8[14:0], 1'b0} ^ (adv8[15] ? 16'h0039 : 16'h0000);
    endfunction

    // Scrambler key: the next eight bits shifted out of bit 15, first bit in bit 0
    function automatic logic [7:0] lfsr_key(input logic [15:0] s);
        for (int b = 0; b < 8; b++) lfsr_key[b] = s[15-b];
    endfunction

`ifdef LANE_REVERSAL_EN
    assign rev_cur = lane_reverse_i;
`else
    assign rev_cur = 1'b0;
`endif

    always_comb begin
        n_cur = '0;
        run = 1'b1;
        for (int i = 0; i < NUM_LANES; i++) begin
            run = run & lane_enable_i[i];
            n_cur = n_cur + NW'(run);
        end
    end

    // Lane configuration is live only while the accumulator is empty
    assign fill     = state == FILL;
    assign idx_z    = idx == '0;
    assign n_eff    = fill && idx_z ? n_cur : n_q;
    assign rev_eff  = fill && idx_z ? rev_cur : rev_q;
    assign os_pad   = fill && valid_i && is_ordered_set_i && !idx_z;
    assign ready_o  = !rst_i && fill && n_eff != '0 && !os_pad;
    assign take     = valid_i && ready_o;
    assign done     = os_pad || (take && (is_ordered_set_i || last_i || NW'(idx) == n_eff - NW'(1)));
    assign out_free = !lane_valid_o || lane_ready_i;
    assign move     = fill ? done && out_free : lane_ready_i;

    always_comb begin
        for (int j = 0; j < NUM_LANES; j++) begin
            grp_d[j] = acc_d[j];
            grp_k[j] = acc_k[j];
            if (take && is_ordered_set_i) begin
                grp_d[j] = data_i;
                grp_k[j] = is_k_i;
            end else if (take && IW'(j) == idx) begin
                grp_d[j] = data_i;
                grp_k[j] = is_k_i;
            end else if (IW'(j) > idx || (os_pad && IW'(j) == idx)) begin
                grp_d[j] = PAD_SYMBOL;
                grp_k[j] = 1'b1;
            end
            src_d[j] = fill ? grp_d[j] : acc_d[j];
            src_k[j] = fill ? grp_k[j] : acc_k[j];
        end
    end

    always_comb begin
        scr_d = '0;
        scr_k = '0;
        act = 1'b0;
        sel = '0;
        sd = '0;
        sk = 1'b0;
        com = 1'b0;
        skp = 1'b0;
        for (int i = 0; i < NUM_LANES; i++) begin
            act = NW'(i) < n_eff;
            sel = rev_eff && act ? IW'(n_eff - NW'(1) - NW'(i)) : IW'(i);
            sd = src_d[sel];
            sk = src_k[sel];
            com = sk && sd == 8'hBC;
            skp = sk && sd == 8'h1C;
            scr_d[8*i +: 8] = !act ? 8'h00 : (sk || bypass_scrambler_i) ? sd : sd ^ lfsr_key(lfsr[i]);
            scr_k[i] = act && sk;
            lfsr_n[i] = (!act || skp) ? lfsr[i] : com ? LFSR_SEED : adv8(lfsr[i]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= FILL;
            idx <= '0;
            n_q <= '0;
            rev_q <= 1'b0;
            lane_valid_o <= 1'b0;
            lane_data_o <= '0;
            lane_is_k_o <= '0;
            for (int i = 0; i < NUM_LANES; i++) lfsr[i] <= LFSR_SEED;
        end else begin
            if (take && idx_z) begin
                n_q <= n_cur;
                rev_q <= rev_cur;
            end
            if (lane_ready_i) lane_valid_o <= 1'b0;
            if (move) begin
                lane_valid_o <= 1'b1;
                lane_data_o <= scr_d;
                lane_is_k_o <= scr_k;
                lfsr <= lfsr_n;
            end
            if (!fill) begin
                if (lane_ready_i) state <= FILL;
            end else if (done) begin
                idx <= '0;
                if (!out_free) begin
                    state <= HOLD;
                    acc_d <= grp_d;
                    acc_k <= grp_k;
                end
            end else if (take) begin
                acc_d[idx] <= data_i;
                acc_k[idx] <= is_k_i;
                idx <= idx + IW'(1);
            end
        end
    end
endmodule
